// File: rtl/picorv32_axi_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter, one transaction in flight; PICORV32_AXI_ARB_RR_EN selects round-robin ties.
// Latency: one cycle from request to s-side valid in IDLE; once granted, all beats pass through combinationally.
// Backpressure: waiting master sees no ready until granted; slave ready/valid pass straight through to the owner.
module picorv32_axi_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,

    input  logic                      m0_axi_awvalid,
    output logic                      m0_axi_awready,
    input  logic [ADDR_WIDTH-1:0]     m0_axi_awaddr,
    input  logic [2:0]                m0_axi_awprot,
    input  logic                      m0_axi_wvalid,
    output logic                      m0_axi_wready,
    input  logic [DATA_WIDTH-1:0]     m0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m0_axi_wstrb,
    output logic                      m0_axi_bvalid,
    input  logic                      m0_axi_bready,
    input  logic                      m0_axi_arvalid,
    output logic                      m0_axi_arready,
    input  logic [ADDR_WIDTH-1:0]     m0_axi_araddr,
    input  logic [2:0]                m0_axi_arprot,
    output logic                      m0_axi_rvalid,
    input  logic                      m0_axi_rready,
    output logic [DATA_WIDTH-1:0]     m0_axi_rdata,

    input  logic                      m1_axi_awvalid,
    output logic                      m1_axi_awready,
    input  logic [ADDR_WIDTH-1:0]     m1_axi_awaddr,
    input  logic [2:0]                m1_axi_awprot,
    input  logic                      m1_axi_wvalid,
    output logic                      m1_axi_wready,
    input  logic [DATA_WIDTH-1:0]     m1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m1_axi_wstrb,
    output logic                      m1_axi_bvalid,
    input  logic                      m1_axi_bready,
    input  logic                      m1_axi_arvalid,
    output logic                      m1_axi_arready,
    input  logic [ADDR_WIDTH-1:0]     m1_axi_araddr,
    input  logic [2:0]                m1_axi_arprot,
    output logic                      m1_axi_rvalid,
    input  logic                      m1_axi_rready,
    output logic [DATA_WIDTH-1:0]     m1_axi_rdata,

    output logic                      s_axi_awvalid,
    input  logic                      s_axi_awready,
    output logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    output logic [2:0]                s_axi_awprot,
    output logic                      s_axi_wvalid,
    input  logic                      s_axi_wready,
    output logic [DATA_WIDTH-1:0]     s_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_bvalid,
    output logic                      s_axi_bready,
    output logic                      s_axi_arvalid,
    input  logic                      s_axi_arready,
    output logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    output logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_rvalid,
    output logic                      s_axi_rready,
    input  logic [DATA_WIDTH-1:0]     s_axi_rdata,

    output logic                      grant,
    output logic                      busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       pick;

    logic in_rd, in_wr;
    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic ar_rdy, r_vld, aw_rdy, w_rdy, b_vld;

    assign in_rd = (state_q == ST_RD);
    assign in_wr = (state_q == ST_WR);

    assign g_awvalid = grant_q ? m1_axi_awvalid : m0_axi_awvalid;
    assign g_wvalid  = grant_q ? m1_axi_wvalid  : m0_axi_wvalid;
    assign g_bready  = grant_q ? m1_axi_bready  : m0_axi_bready;
    assign g_arvalid = grant_q ? m1_axi_arvalid : m0_axi_arvalid;
    assign g_rready  = grant_q ? m1_axi_rready  : m0_axi_rready;

    assign s_axi_awaddr = grant_q ? m1_axi_awaddr : m0_axi_awaddr;
    assign s_axi_awprot = grant_q ? m1_axi_awprot : m0_axi_awprot;
    assign s_axi_wdata  = grant_q ? m1_axi_wdata  : m0_axi_wdata;
    assign s_axi_wstrb  = grant_q ? m1_axi_wstrb  : m0_axi_wstrb;
    assign s_axi_araddr = grant_q ? m1_axi_araddr : m0_axi_araddr;
    assign s_axi_arprot = grant_q ? m1_axi_arprot : m0_axi_arprot;

    // Done flags stop a channel from being re-presented once its handshake has happened.
    assign s_axi_arvalid = in_rd & g_arvalid & ~ar_done_q;
    assign s_axi_rready  = in_rd & g_rready;
    assign s_axi_awvalid = in_wr & g_awvalid & ~aw_done_q;
    assign s_axi_wvalid  = in_wr & g_wvalid & ~w_done_q;
    assign s_axi_bready  = in_wr & g_bready;

    assign ar_rdy = in_rd & s_axi_arready & ~ar_done_q;
    assign r_vld  = in_rd & s_axi_rvalid;
    assign aw_rdy = in_wr & s_axi_awready & ~aw_done_q;
    assign w_rdy  = in_wr & s_axi_wready & ~w_done_q;
    assign b_vld  = in_wr & s_axi_bvalid;

    assign m0_axi_arready = ar_rdy & ~grant_q;
    assign m1_axi_arready = ar_rdy &  grant_q;
    assign m0_axi_rvalid  = r_vld  & ~grant_q;
    assign m1_axi_rvalid  = r_vld  &  grant_q;
    assign m0_axi_awready = aw_rdy & ~grant_q;
    assign m1_axi_awready = aw_rdy &  grant_q;
    assign m0_axi_wready  = w_rdy  & ~grant_q;
    assign m1_axi_wready  = w_rdy  &  grant_q;
    assign m0_axi_bvalid  = b_vld  & ~grant_q;
    assign m1_axi_bvalid  = b_vld  &  grant_q;
    assign m0_axi_rdata   = s_axi_rdata;
    assign m1_axi_rdata   = s_axi_rdata;

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        pick      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m0_axi_arvalid | m0_axi_awvalid | m1_axi_arvalid | m1_axi_awvalid) begin
`ifdef PICORV32_AXI_ARB_RR_EN
                    if ((m0_axi_arvalid | m0_axi_awvalid) & (m1_axi_arvalid | m1_axi_awvalid))
                        pick = ~last_q;
                    else
                        pick = ~(m0_axi_arvalid | m0_axi_awvalid);
`else
                    pick = ~(m0_axi_arvalid | m0_axi_awvalid);
`endif
                    grant_d   = pick;
                    last_d    = pick;
                    // Reads win when a master raises both valids together.
                    state_d   = (pick ? m1_axi_arvalid : m0_axi_arvalid) ? ST_RD : ST_WR;
                    ar_done_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_RD: begin
                if (s_axi_arvalid & s_axi_arready) ar_done_d = 1'b1;
                if (s_axi_rvalid & s_axi_rready)   state_d   = ST_IDLE;
            end
            ST_WR: begin
                if (s_axi_awvalid & s_axi_awready) aw_done_d = 1'b1;
                if (s_axi_wvalid & s_axi_wready)   w_done_d  = 1'b1;
                if (s_axi_bvalid & s_axi_bready)   state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_picorv32_axi_arbiter.sv
// Directed bench for picorv32_axi_arbiter: two master drivers plus a small AXI4-Lite memory slave.
module tb_picorv32_axi_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m_awvalid [2];
    logic        m_awready [2];
    logic [31:0] m_awaddr  [2];
    logic        m_wvalid  [2];
    logic        m_wready  [2];
    logic [31:0] m_wdata   [2];
    logic [3:0]  m_wstrb   [2];
    logic        m_bvalid  [2];
    logic        m_bready  [2];
    logic        m_arvalid [2];
    logic        m_arready [2];
    logic [31:0] m_araddr  [2];
    logic        m_rvalid  [2];
    logic        m_rready  [2];
    logic [31:0] m_rdata   [2];

    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [2:0]  s_awprot, s_arprot;
    logic        grant, busy;

    picorv32_axi_arbiter dut (
        .sys_clk(clk), .sys_rst(rst),
        .m0_axi_awvalid(m_awvalid[0]), .m0_axi_awready(m_awready[0]), .m0_axi_awaddr(m_awaddr[0]),
        .m0_axi_awprot(3'b000), .m0_axi_wvalid(m_wvalid[0]), .m0_axi_wready(m_wready[0]),
        .m0_axi_wdata(m_wdata[0]), .m0_axi_wstrb(m_wstrb[0]), .m0_axi_bvalid(m_bvalid[0]),
        .m0_axi_bready(m_bready[0]), .m0_axi_arvalid(m_arvalid[0]), .m0_axi_arready(m_arready[0]),
        .m0_axi_araddr(m_araddr[0]), .m0_axi_arprot(3'b000), .m0_axi_rvalid(m_rvalid[0]),
        .m0_axi_rready(m_rready[0]), .m0_axi_rdata(m_rdata[0]),
        .m1_axi_awvalid(m_awvalid[1]), .m1_axi_awready(m_awready[1]), .m1_axi_awaddr(m_awaddr[1]),
        .m1_axi_awprot(3'b001), .m1_axi_wvalid(m_wvalid[1]), .m1_axi_wready(m_wready[1]),
        .m1_axi_wdata(m_wdata[1]), .m1_axi_wstrb(m_wstrb[1]), .m1_axi_bvalid(m_bvalid[1]),
        .m1_axi_bready(m_bready[1]), .m1_axi_arvalid(m_arvalid[1]), .m1_axi_arready(m_arready[1]),
        .m1_axi_araddr(m_araddr[1]), .m1_axi_arprot(3'b001), .m1_axi_rvalid(m_rvalid[1]),
        .m1_axi_rready(m_rready[1]), .m1_axi_rdata(m_rdata[1]),
        .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready), .s_axi_awaddr(s_awaddr),
        .s_axi_awprot(s_awprot), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_bvalid(s_bvalid),
        .s_axi_bready(s_bready), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_araddr(s_araddr), .s_axi_arprot(s_arprot), .s_axi_rvalid(s_rvalid),
        .s_axi_rready(s_rready), .s_axi_rdata(s_rdata),
        .grant(grant), .busy(busy)
    );

    // Memory slave; async_m returns read data in the same cycle as arready.
    logic        async_m = 1'b0;
    logic [31:0] mem [256];
    logic        r_v, aw_got, w_got, b_v;
    logic [31:0] r_d, aw_a, w_d;
    logic [3:0]  w_s;

    assign s_arready = async_m ? 1'b1 : ~r_v;
    assign s_rvalid  = async_m ? s_arvalid : r_v;
    assign s_rdata   = async_m ? mem[s_araddr[9:2]] : r_d;
    assign s_awready = ~aw_got;
    assign s_wready  = ~w_got;
    assign s_bvalid  = b_v;

    always @(posedge clk) begin
        if (rst) begin
            r_v <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_v <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + 32'(i);
        end else begin
            if (!async_m && s_arvalid && s_arready) begin r_v <= 1'b1; r_d <= mem[s_araddr[9:2]]; end
            if (r_v && s_rready) r_v <= 1'b0;
            if (s_awvalid && s_awready) begin aw_got <= 1'b1; aw_a <= s_awaddr; end
            if (s_wvalid && s_wready) begin w_got <= 1'b1; w_d <= s_wdata; w_s <= s_wstrb; end
            if (aw_got && w_got && !b_v) begin
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) mem[aw_a[9:2]][8*b +: 8] <= w_d[8*b +: 8];
                b_v <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (b_v && s_bready) b_v <= 1'b0;
        end
    end

    int          cyc = 0;
    int          ar_hs_cyc = 0, r_hs_cyc = 0, b_hs_cyc = 0, ar_gap = 0;
    int          b1_cnt = 0, m1_act_cnt = 0;
    logic [31:0] last_s_araddr = 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_arvalid && s_arready) begin
            ar_gap <= cyc - r_hs_cyc; ar_hs_cyc <= cyc; last_s_araddr <= s_araddr;
        end
        if (s_rvalid && s_rready) r_hs_cyc <= cyc;
        if (s_bvalid && s_bready) b_hs_cyc <= cyc;
        if (m_bvalid[1] && m_bready[1]) b1_cnt <= b1_cnt + 1;
        if (m_arready[1] | m_awready[1] | m_wready[1] | m_rvalid[1] | m_bvalid[1])
            m1_act_cnt <= m1_act_cnt + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the R handshake (IDLE cycle).
    task automatic do_read(input int m, input logic [31:0] a, output logic [31:0] d,
                           output int hc, output int g, output int n_ar);
        logic drop_ar = 1'b0;
        logic fin = 1'b0;
        d = 32'h0; hc = -1; g = -1; n_ar = -1;
        m_arvalid[m] = 1'b1; m_araddr[m] = a;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (drop_ar) m_arvalid[m] = 1'b0;
            if (fin) break;
            if (m_arvalid[m] && m_arready[m]) begin drop_ar = 1'b1; hc = cyc; g = int'(grant); n_ar = n; end
            if (m_rvalid[m]) begin d = m_rdata[m]; fin = 1'b1; end
        end
        m_arvalid[m] = 1'b0;
        if (!fin) chk("read_timeout", 32'(fin), 32'd1);
    endtask

    task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int wdly, output int g);
        logic drop_aw = 1'b0;
        logic drop_w = 1'b0;
        logic fin = 1'b0;
        g = -1;
        m_awvalid[m] = 1'b1; m_awaddr[m] = a;
        m_wdata[m] = d; m_wstrb[m] = s; m_wvalid[m] = (wdly == 0);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (drop_aw) m_awvalid[m] = 1'b0;
            if (drop_w)  m_wvalid[m] = 1'b0;
            if (fin) break;
            if (!drop_w && n + 1 == wdly) m_wvalid[m] = 1'b1;
            if (m_awvalid[m] && m_awready[m]) begin drop_aw = 1'b1; g = int'(grant); end
            if (m_wvalid[m] && m_wready[m]) drop_w = 1'b1;
            if (m_bvalid[m]) fin = 1'b1;
        end
        m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0;
        if (!fin) chk("write_timeout", 32'(fin), 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({m_awready[0], m_awready[1], m_wready[0], m_wready[1], m_bvalid[0], m_bvalid[1],
                    m_arready[0], m_arready[1], m_rvalid[0], m_rvalid[1],
                    s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready, busy, grant});
    endfunction

    function automatic logic exp_tie(input logic last_m);
`ifdef PICORV32_AXI_ARB_RR_EN
        return ~last_m;
`else
        return (last_m & 1'b0);
`endif
    endfunction

    logic [31:0] d0, d1;
    int          h0, h1, g0, g1, n0, n1, gw, snap;
    logic        last_m, first, ef;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i] = 1'b0; m_awaddr[i] = 32'h0; m_wvalid[i] = 1'b0; m_wdata[i] = 32'h0;
            m_wstrb[i] = 4'h0; m_bready[i] = 1'b1; m_arvalid[i] = 1'b0; m_araddr[i] = 32'h0;
            m_rready[i] = 1'b1;
        end
        last_m = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_outs", all_outs(), 32'd0);

        // Single m0 read of 0x100.
        snap = m1_act_cnt;
        do_read(0, 32'h100, d0, h0, g0, n0);
        chk("rd0_latency", 32'(n0), 32'd0);
        chk("rd0_s_araddr", last_s_araddr, 32'h100);
        chk("rd0_data", d0, 32'hA500_0040);
        chk("rd0_grant", 32'(g0), 32'd0);
        chk("rd0_m1_quiet", 32'(m1_act_cnt - snap), 32'd0);
        chk("rd0_idle_after", 32'(busy), 32'd0);
        last_m = 1'b0;

        // Simultaneous reads, four rounds.
        for (int k = 0; k < 4; k++) begin
            fork
                do_read(0, 32'h100, d0, h0, g0, n0);
                do_read(1, 32'h104, d1, h1, g1, n1);
            join
            first = (h1 < h0);
            ef = exp_tie(last_m);
            chk("tie_first", 32'(first), 32'(ef));
            chk("tie_dead_slot", 32'(ar_gap), 32'd2);
            chk("tie_d0", d0, 32'hA500_0040);
            chk("tie_d1", d1, 32'hA500_0041);
            chk("tie_g1", 32'(g1), 32'd1);
            last_m = ~ef;
        end

        // m1 write with W two cycles behind AW, then readback and a half-word strobe.
        snap = b1_cnt;
        do_write(1, 32'h40, 32'hDEAD_BEEF, 4'hF, 2, gw);
        chk("wr1_grant", 32'(gw), 32'd1);
        @(negedge clk);
        chk("wr1_one_b", 32'(b1_cnt - snap), 32'd1);
        do_read(0, 32'h40, d0, h0, g0, n0);
        chk("wr1_readback", d0, 32'hDEAD_BEEF);
        do_write(1, 32'h40, 32'h1234_5678, 4'b0011, 0, gw);
        do_read(0, 32'h40, d0, h0, g0, n0);
        chk("wr1_strobe", d0, 32'hDEAD_5678);

        // m0 raises AR and AW together: read first.
        fork
            do_read(0, 32'h80, d0, h0, g0, n0);
            do_write(0, 32'h84, 32'hCAFE_F00D, 4'hF, 0, gw);
        join
        chk("rw_read_first", 32'(r_hs_cyc < b_hs_cyc), 32'd1);
        chk("rw_rdata", d0, 32'hA500_0020);
        chk("rw_wgrant", 32'(gw), 32'd0);

        // Slave answers the read in the same cycle as arready.
        async_m = 1'b1;
        do_read(1, 32'h84, d1, h1, g1, n1);
        chk("async_data", d1, 32'hCAFE_F00D);
        chk("async_same_cycle", 32'(r_hs_cyc - ar_hs_cyc), 32'd0);
        chk("async_idle", 32'(busy), 32'd0);
        async_m = 1'b0;

        // Reset in WR after only the AW handshake.
        m_awvalid[1] = 1'b1; m_awaddr[1] = 32'h60; m_wvalid[1] = 1'b0;
        @(negedge clk);
        chk("wr_rst_awready", 32'(m_awready[1]), 32'd1);
        @(negedge clk);
        chk("wr_rst_aw_gated", 32'(m_awready[1]), 32'd0);
        chk("wr_rst_busy", 32'(busy), 32'd1);
        chk("wr_rst_grant", 32'(grant), 32'd1);
        m_awvalid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_outs", all_outs(), 32'd0);
        fork
            do_read(0, 32'h100, d0, h0, g0, n0);
            do_read(1, 32'h104, d1, h1, g1, n1);
        join
        chk("post_rst_tie_m0", 32'(h0 < h1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
